// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stall arbitration, exception/ERET redirect, bus-safe flush deferral.
// Optional STALL_WATCHDOG_EN adds wdog_err, a sticky flag for a stall that never releases.
module pipe_ctrl #(
  parameter logic [31:0] EXC_BASE      = 32'h80000000,
  parameter logic [31:0] GEN_OFFSET    = 32'h00000180,
  parameter logic [31:0] REFILL_OFFSET = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        bus_busy,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
`ifdef STALL_WATCHDOG_EN
  output logic        wdog_err,
`endif
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, WAIT_BUS, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] stall_cycles_q;

  function automatic logic [31:0] vec_target(input logic [31:0] code, input logic [31:0] epc);
    logic [31:0] tgt;
    case (code)
      32'h2, 32'h3: tgt = EXC_BASE + REFILL_OFFSET;
      32'he:        tgt = epc;
      default:      tgt = EXC_BASE + GEN_OFFSET;
    endcase
    return tgt;
  endfunction

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    epc_d   = epc_q;
    stall   = 6'b000000;
    flush   = 1'b0;
    new_pc  = 32'h0;
    case (state_q)
      RUN: begin
        if (excepttype_i != 32'h0) begin
          if (!bus_busy) begin
            flush  = 1'b1;
            new_pc = vec_target(excepttype_i, cp0_epc_i);
          end else begin
            // EPC is captured now so an ERET returns to the address seen at acceptance.
            stall   = 6'b111111;
            code_d  = excepttype_i;
            epc_d   = cp0_epc_i;
            state_d = WAIT_BUS;
          end
        end else if (stallreq_mem) begin
          stall = 6'b011111;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else if (stallreq_if) begin
          stall = 6'b000011;
        end
      end
      WAIT_BUS: begin
        stall = 6'b111111;
        if (!bus_busy) state_d = FLUSH;
      end
      FLUSH: begin
        flush   = 1'b1;
        new_pc  = vec_target(code_q, epc_q);
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      stall  = 6'b000000;
      flush  = 1'b0;
      new_pc = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      code_q         <= 32'h0;
      epc_q          <= 32'h0;
      stall_cycles_q <= 32'h0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      if (stall != 6'b000000) stall_cycles_q <= stall_cycles_q + 32'h1;
    end
  end

  assign stall_cycles = stall_cycles_q;

`ifdef STALL_WATCHDOG_EN
  logic [15:0] wdog_cnt_q;
  logic        wdog_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= 16'h0;
      wdog_err_q <= 1'b0;
    end else begin
      if (stall != 6'b000000 && !flush) begin
        if (wdog_cnt_q != 16'hFFFF) wdog_cnt_q <= wdog_cnt_q + 16'h1;
      end else begin
        wdog_cnt_q <= 16'h0;
      end
      if (wdog_cnt_q == 16'hFFFF) wdog_err_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; inputs change 1ns after each rising edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, bus_busy;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
`ifdef STALL_WATCHDOG_EN
  logic        wdog_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .bus_busy     (bus_busy),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
`ifdef STALL_WATCHDOG_EN
    .wdog_err     (wdog_err),
`endif
    .stall_cycles (stall_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] s, input logic f, input logic [31:0] pc);
    #1;
    chk({tag, ".stall"}, {26'h0, stall}, {26'h0, s});
    chk({tag, ".flush"}, {31'h0, flush}, {31'h0, f});
    chk({tag, ".new_pc"}, new_pc, pc);
  endtask

  initial begin
    rst = 1'b1;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0; bus_busy = 0;
    excepttype_i = 32'h0; cp0_epc_i = 32'h0;
    step(); step();
    chk_out("reset", 6'h00, 1'b0, 32'h0);
    chk("reset.stall_cycles", stall_cycles, 32'h0);
    rst = 1'b0;
    step();

    // MEM outranks ID for three cycles
    stallreq_mem = 1; stallreq_id = 1;
    for (int i = 0; i < 3; i++) begin
      chk_out("mem_id", 6'b011111, 1'b0, 32'h0);
      step();
      chk("mem_id.cycles", stall_cycles, 32'(i + 1));
    end
    stallreq_mem = 0; stallreq_ex = 1; stallreq_if = 1;
    chk_out("ex_id_if", 6'b001111, 1'b0, 32'h0);
    step();
    stallreq_ex = 0;
    chk_out("id_if", 6'b000111, 1'b0, 32'h0);
    step();
    stallreq_id = 0;
    chk_out("if_only", 6'b000011, 1'b0, 32'h0);
    step();
    stallreq_if = 0;
    chk_out("idle", 6'b000000, 1'b0, 32'h0);
    chk("prio.cycles", stall_cycles, 32'd6);

    // Syscall with no bus activity: immediate flush overrides a MEM stall
    excepttype_i = 32'h8; stallreq_mem = 1;
    chk_out("syscall", 6'b000000, 1'b1, 32'h80000180);
    step();
    excepttype_i = 32'h0; stallreq_mem = 0;
    chk_out("syscall.after", 6'b000000, 1'b0, 32'h0);
    chk("syscall.cycles", stall_cycles, 32'd6);

    // ERET deferred by a busy bus; EPC changes after acceptance must not matter
    excepttype_i = 32'he; cp0_epc_i = 32'h80001234; bus_busy = 1;
    chk_out("eret.accept", 6'b111111, 1'b0, 32'h0);
    step();
    excepttype_i = 32'h0; cp0_epc_i = 32'hdeadbeef;
    for (int i = 0; i < 3; i++) begin
      chk_out("eret.wait", 6'b111111, 1'b0, 32'h0);
      step();
    end
    bus_busy = 0;
    chk_out("eret.drain", 6'b111111, 1'b0, 32'h0);
    step();
    chk_out("eret.flush", 6'b000000, 1'b1, 32'h80001234);
    step();
    chk_out("eret.nosecond", 6'b000000, 1'b0, 32'h0);
    chk("eret.cycles", stall_cycles, 32'd11);
    step();
    chk_out("eret.nosecond2", 6'b000000, 1'b0, 32'h0);

    // TLB refill while EX requests a stall
    excepttype_i = 32'h2; stallreq_ex = 1;
    chk_out("refill", 6'b000000, 1'b1, 32'h80000000);
    step();
    stallreq_ex = 0; excepttype_i = 32'h1f;
    chk_out("tlbmod", 6'b000000, 1'b1, 32'h80000180);
    step();
    excepttype_i = 32'h7;
    chk_out("other", 6'b000000, 1'b1, 32'h80000180);
    step();
    excepttype_i = 32'h3; bus_busy = 1;
    chk_out("refill.defer", 6'b111111, 1'b0, 32'h0);
    step();
    excepttype_i = 32'h0; bus_busy = 0;
    step();
    chk_out("refill.flush", 6'b000000, 1'b1, 32'h80000000);
    step();

    // Reset during WAIT_BUS discards the pending exception
    excepttype_i = 32'hc; bus_busy = 1;
    step();
    excepttype_i = 32'h0;
    chk_out("rst.waiting", 6'b111111, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    chk_out("rst.applied", 6'b000000, 1'b0, 32'h0);
    chk("rst.cycles", stall_cycles, 32'h0);
    rst = 1'b0; bus_busy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("rst.noflush", 6'b000000, 1'b0, 32'h0);
    end

`ifdef STALL_WATCHDOG_EN
    chk("wdog.idle", {31'h0, wdog_err}, 32'h0);
    stallreq_ex = 1;
    repeat (65535) step();
    chk("wdog.edge", {31'h0, wdog_err}, 32'h0);
    step();
    chk("wdog.set", {31'h0, wdog_err}, 32'h1);
    stallreq_ex = 0;
    step(); step();
    chk("wdog.sticky", {31'h0, wdog_err}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wdog.rst", {31'h0, wdog_err}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
